// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - fetch stage bus bundle: imem request/response, redirect, decode handshake
//   master : fetch stage side (drives imem_req_*, id_valid/id_inst/id_pc)
//   slave  : environment side (memory, execute redirect, decode)
interface fetch_stage_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_inst;
  logic [31:0] id_pc;

  modport master (
    output imem_req_valid, imem_req_addr, id_valid, id_inst, id_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, id_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, id_valid, id_inst, id_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, id_ready
  );
endinterface

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - RV32I fetch stage: PC, in-order imem requests, instruction FIFO, redirect flush
//   clk, rst_n            : clock, asynchronous active-low reset
//   bus.imem_req_*        : word fetch request (valid/ready, addr = PC register)
//   bus.imem_rsp_*        : in-order response, one pulse per accepted request
//   bus.redirect_*        : taken branch/jump from execute, overrides everything
//   bus.id_*              : instruction + PC to decode (valid/ready)
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_stage_if.master bus
);
  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned CW  = AW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef logic [CW-1:0] cnt_t;
  typedef logic [CW:0]   occ_t;
  typedef logic [AW-1:0] ptr_t;

  logic [31:0] pc_q, pc_d;
  cnt_t        out_q, out_d;
  cnt_t        drop_q, drop_d;
  cnt_t        cnt_q, cnt_d;
  ptr_t        rd_q, rd_d, wr_q, wr_d;
  ptr_t        tag_rd_q, tag_rd_d, tag_wr_q, tag_wr_d;

  logic [31:0] fifo_inst_q [DEPTH];
  logic [31:0] fifo_pc_q   [DEPTH];
  logic [31:0] tag_q       [DEPTH];

  logic rsp_fire, pop, push, accept, req_valid, id_valid;
  occ_t occ;
  logic unused_pc_lsbs;

  assign unused_pc_lsbs = ^bus.redirect_pc[1:0];

  // A response with nothing outstanding is a protocol error and is ignored.
  assign rsp_fire = bus.imem_rsp_valid & (out_q != '0);
  assign id_valid = (cnt_q != '0) & !bus.redirect_valid;
  assign pop      = id_valid & bus.id_ready;
  // Slots already promised (in flight + buffered), counting a same-cycle pop as freed.
  assign occ       = occ_t'(out_q) + occ_t'(cnt_q) - occ_t'(pop);
  assign req_valid = rst_n & !bus.redirect_valid & (occ < occ_t'(DEPTH));
  assign accept    = req_valid & bus.imem_req_ready;
  // Stale responses (pre-redirect fetches) are counted off via drop_q.
  assign push      = rsp_fire & (drop_q == '0) & !bus.redirect_valid;

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = pc_q;
  assign bus.id_valid       = id_valid;
  assign bus.id_inst        = id_valid ? fifo_inst_q[rd_q] : NOP;
  assign bus.id_pc          = id_valid ? fifo_pc_q[rd_q]   : 32'h0;

  always_comb begin
    pc_d     = pc_q;
    out_d    = out_q + cnt_t'(accept) - cnt_t'(rsp_fire);
    drop_d   = drop_q;
    cnt_d    = cnt_q + cnt_t'(push) - cnt_t'(pop);
    rd_d     = rd_q + ptr_t'(pop);
    wr_d     = wr_q + ptr_t'(push);
    tag_wr_d = tag_wr_q + ptr_t'(accept);
    tag_rd_d = tag_rd_q + ptr_t'(rsp_fire);
    if (accept) pc_d = pc_q + 32'd4;
    if (rsp_fire && drop_q != '0) drop_d = drop_q - cnt_t'(1);
    if (bus.redirect_valid) begin
      pc_d   = {bus.redirect_pc[31:2], 2'b00};
      cnt_d  = '0;
      rd_d   = '0;
      wr_d   = '0;
      // Everything still in flight after this cycle's response belongs to the old path.
      drop_d = out_q - cnt_t'(rsp_fire);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= RESET_PC;
      out_q    <= '0;
      drop_q   <= '0;
      cnt_q    <= '0;
      rd_q     <= '0;
      wr_q     <= '0;
      tag_rd_q <= '0;
      tag_wr_q <= '0;
    end else begin
      pc_q     <= pc_d;
      out_q    <= out_d;
      drop_q   <= drop_d;
      cnt_q    <= cnt_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      tag_rd_q <= tag_rd_d;
      tag_wr_q <= tag_wr_d;
    end
  end

  // Payload storage needs no reset: validity is tracked by the counters.
  // The tag FIFO survives redirects because stale responses still retire their tags.
  always_ff @(posedge clk) begin
    if (accept) tag_q[tag_wr_q] <= pc_q;
    if (push) begin
      fifo_inst_q[wr_q] <= bus.imem_rsp_data;
      fifo_pc_q[wr_q]   <= tag_q[tag_rd_q];
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - testbench for fetch_stage
module tb_fetch_stage;
  localparam int unsigned DEPTH = 2;
  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_stage_if bus_if ();

  fetch_stage #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_if)
  );

  typedef struct { logic [31:0] addr; int due; } mreq_t;
  mreq_t mq[$];

  typedef struct {
    logic ir; logic rv; logic [31:0] rpc; logic spur;
    logic rqv; logic [31:0] addr; logic idv; logic [31:0] idpc;
  } vec_t;
  vec_t vec [21];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int pops = 0;
  logic [31:0] exp_pc, exp_req;

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return pc ^ 32'h5A5A_1234;
  endfunction

  function automatic vec_t mk(input logic ir, input logic rv, input logic [31:0] rpc, input logic spur,
                              input logic rqv, input logic [31:0] addr, input logic idv, input logic [31:0] idpc);
    vec_t v;
    v.ir = ir; v.rv = rv; v.rpc = rpc; v.spur = spur;
    v.rqv = rqv; v.addr = addr; v.idv = idv; v.idpc = idpc;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp_v);
    end
  endtask

  task automatic check_reset(input string nm);
    chk({nm, "_rqv"},  32'(bus_if.imem_req_valid), 32'd0);
    chk({nm, "_addr"}, bus_if.imem_req_addr, 32'h0);
    chk({nm, "_idv"},  32'(bus_if.id_valid), 32'd0);
    chk({nm, "_inst"}, bus_if.id_inst, NOP);
    chk({nm, "_idpc"}, bus_if.id_pc, 32'h0);
  endtask

  // Memory model: in-order responses, head released once its due cycle is reached.
  task automatic drive_inputs(input logic rr, input logic ir, input logic rv, input logic [31:0] rpc, input logic spur);
    bus_if.imem_req_ready = rr;
    bus_if.id_ready       = ir;
    bus_if.redirect_valid = rv;
    bus_if.redirect_pc    = rpc;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      bus_if.imem_rsp_valid = 1'b1;
      bus_if.imem_rsp_data  = inst_of(mq[0].addr);
      void'(mq.pop_front());
    end else begin
      bus_if.imem_rsp_valid = spur;
      bus_if.imem_rsp_data  = 32'hDEAD_BEEF;
    end
  endtask

  task automatic advance(input int lat);
    mreq_t r;
    if (bus_if.imem_req_valid && bus_if.imem_req_ready) begin
      r.addr = bus_if.imem_req_addr;
      r.due  = cyc + lat;
      mq.push_back(r);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset(input string nm);
    rst_n = 1'b0;
    mq.delete();
    drive_inputs(L, L, L, 32'h0, L);
    #1;
    check_reset(nm);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    bus_if.imem_req_ready = 1'b0;
    bus_if.id_ready       = 1'b0;
    bus_if.redirect_valid = 1'b0;
    bus_if.redirect_pc    = 32'h0;
    bus_if.imem_rsp_valid = 1'b0;
    bus_if.imem_rsp_data  = 32'h0;

    //            ir rv rpc           spur rqv addr          idv idpc
    vec[0]  = mk(H, L, 32'h0,        L,   H,  32'h0000_0000, L, 32'h0);
    vec[1]  = mk(H, L, 32'h0,        L,   H,  32'h0000_0004, L, 32'h0);
    vec[2]  = mk(H, L, 32'h0,        L,   H,  32'h0000_0008, H, 32'h0000_0000);
    vec[3]  = mk(H, L, 32'h0,        L,   H,  32'h0000_000C, H, 32'h0000_0004);
    vec[4]  = mk(L, L, 32'h0,        L,   L,  32'h0000_0010, H, 32'h0000_0008);
    vec[5]  = mk(L, L, 32'h0,        H,   L,  32'h0000_0010, H, 32'h0000_0008);
    vec[6]  = mk(L, L, 32'h0,        L,   L,  32'h0000_0010, H, 32'h0000_0008);
    vec[7]  = mk(L, L, 32'h0,        L,   L,  32'h0000_0010, H, 32'h0000_0008);
    vec[8]  = mk(L, L, 32'h0,        L,   L,  32'h0000_0010, H, 32'h0000_0008);
    vec[9]  = mk(H, L, 32'h0,        L,   H,  32'h0000_0010, H, 32'h0000_0008);
    vec[10] = mk(H, L, 32'h0,        L,   H,  32'h0000_0014, H, 32'h0000_000C);
    vec[11] = mk(H, L, 32'h0,        L,   H,  32'h0000_0018, H, 32'h0000_0010);
    vec[12] = mk(H, H, 32'h100,      L,   L,  32'h0000_001C, L, 32'h0);
    vec[13] = mk(H, L, 32'h0,        L,   H,  32'h0000_0100, L, 32'h0);
    vec[14] = mk(H, L, 32'h0,        L,   H,  32'h0000_0104, L, 32'h0);
    vec[15] = mk(H, L, 32'h0,        L,   H,  32'h0000_0108, H, 32'h0000_0100);
    vec[16] = mk(H, H, 32'hFFFF_FFFE, L,  L,  32'h0000_010C, L, 32'h0);
    vec[17] = mk(H, L, 32'h0,        L,   H,  32'hFFFF_FFFC, L, 32'h0);
    vec[18] = mk(H, L, 32'h0,        L,   H,  32'h0000_0000, L, 32'h0);
    vec[19] = mk(H, L, 32'h0,        L,   H,  32'h0000_0004, H, 32'hFFFF_FFFC);
    vec[20] = mk(H, L, 32'h0,        L,   H,  32'h0000_0008, H, 32'h0000_0000);

    // Directed table: 1-cycle memory, stall, spurious response, redirects incl. wrap.
    do_reset("rst0");
    for (int i = 0; i < 21; i++) begin
      drive_inputs(H, vec[i].ir, vec[i].rv, vec[i].rpc, vec[i].spur);
      @(negedge clk);
      chk($sformatf("t%0d_rqv", i),  32'(bus_if.imem_req_valid), 32'(vec[i].rqv));
      chk($sformatf("t%0d_addr", i), bus_if.imem_req_addr, vec[i].addr);
      chk($sformatf("t%0d_idv", i),  32'(bus_if.id_valid), 32'(vec[i].idv));
      chk($sformatf("t%0d_idpc", i), bus_if.id_pc, vec[i].idpc);
      chk($sformatf("t%0d_inst", i), bus_if.id_inst, vec[i].idv ? inst_of(vec[i].idpc) : NOP);
      advance(1);
    end

    // Redirect with two requests in flight, 2-cycle memory: both stale responses dropped.
    do_reset("rst1");
    for (int i = 0; i < 2; i++) begin
      drive_inputs(H, H, L, 32'h0, L);
      @(negedge clk);
      advance(2);
    end
    chk("r2_inflight", 32'(mq.size()), 32'd2);
    drive_inputs(H, H, H, 32'h0000_0100, L);
    @(negedge clk);
    chk("r2_idv_r", 32'(bus_if.id_valid), 32'd0);
    chk("r2_rqv_r", 32'(bus_if.imem_req_valid), 32'd0);
    advance(2);
    begin
      int n;
      bit seen;
      seen = 1'b0;
      for (n = 1; n <= 12 && !seen; n++) begin
        drive_inputs(H, H, L, 32'h0, L);
        @(negedge clk);
        if (n == 1) begin
          chk("r2_req_rv", 32'(bus_if.imem_req_valid), 32'd1);
          chk("r2_req_a", bus_if.imem_req_addr, 32'h0000_0100);
        end
        if (bus_if.id_valid) begin
          seen = 1'b1;
          chk("r2_first_pc", bus_if.id_pc, 32'h0000_0100);
          chk("r2_latency", 32'(n), 32'd4);
        end
        advance(2);
      end
      if (!seen) chk("r2_timeout", 32'd0, 32'd1);
    end

    // Randomized run against a PC-sequence model, with a mid-stream reset.
    do_reset("rst2");
    exp_pc  = 32'h0;
    exp_req = 32'h0;
    for (int i = 0; i < 2000; i++) begin
      logic rv, acc;
      logic [31:0] rpc;
      rv  = ($urandom_range(0, 24) == 0);
      rpc = (i % 7 == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      drive_inputs(($urandom_range(0, 9) < 7), ($urandom_range(0, 3) != 0), rv, rpc, L);
      if (i == 1000) begin
        #2 rst_n = 1'b0;
        #1 check_reset("midrst");
        mq.delete();
        drive_inputs(L, L, L, 32'h0, L);
        exp_pc  = 32'h0;
        exp_req = 32'h0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cyc++;
      end else begin
        @(negedge clk);
        if (rv) begin
          chk("rnd_redir_idv", 32'(bus_if.id_valid), 32'd0);
          chk("rnd_redir_rqv", 32'(bus_if.imem_req_valid), 32'd0);
        end
        if (bus_if.id_valid && bus_if.id_ready) begin
          chk("rnd_pc", bus_if.id_pc, exp_pc);
          chk("rnd_inst", bus_if.id_inst, inst_of(exp_pc));
          exp_pc = exp_pc + 32'd4;
          pops++;
        end else if (!bus_if.id_valid) begin
          chk("rnd_nop", bus_if.id_inst, NOP);
        end
        acc = bus_if.imem_req_valid && bus_if.imem_req_ready;
        if (acc) begin
          chk("rnd_addr", bus_if.imem_req_addr, exp_req);
          exp_req = exp_req + 32'd4;
        end
        if (rv) begin
          exp_pc  = {rpc[31:2], 2'b00};
          exp_req = {rpc[31:2], 2'b00};
        end
        chk("rnd_inflight", 32'((mq.size() + int'(acc)) <= int'(DEPTH)), 32'd1);
        advance(int'($urandom_range(1, 4)));
      end
    end
    chk("rnd_progress", 32'(pops > 200), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
